// File: rtl/adder_arb_pkg.sv
// Shared constants and FSM state encoding for the adder arbiter.
package adder_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 16;
    localparam int ID_W    = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage : adder_arb_pkg

// File: rtl/adder16.sv
// Existing WIDTH-bit ripple adder with carry-out; used unmodified as the datapath.
module adder16 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule : adder16

// File: rtl/rr_arbiter4.sv
// Four-way round-robin winner selection. The search begins one past the
// previous winner and wraps; grant is all-zero when nobody requests.
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] last_grant,
    output logic [3:0] grant,
    output logic [1:0] grant_id
);

    logic [1:0] w_idx;
    logic       w_found;

    // Scan the four positions starting after last_grant and pick the first requester.
    always_comb begin
        grant    = 4'b0000;
        grant_id = 2'd0;
        w_found  = 1'b0;
        w_idx    = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            w_idx = last_grant + 2'(i);
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                grant_id     = w_idx;
                w_found      = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule : rr_arbiter4

// File: rtl/adder_arbiter.sv
// Shares one adder among NUM_REQ requesters. A round-robin arbiter picks one
// valid requester per cycle, its operands are added and the result is held in
// a single output register until downstream accepts it. A result can be
// drained and replaced in the same cycle, so throughput is one per cycle.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic [15:0]              op_count
);

    state_t            r_state;
    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;
    logic [WIDTH-1:0]  r_rsp_sum;
    logic              r_rsp_cout;
    logic [15:0]       r_op_count;
    logic [ID_W-1:0]   r_last_grant;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_id;
    logic               w_can_accept;
    logic               w_transfer;
    logic [WIDTH-1:0]   w_op_a;
    logic [WIDTH-1:0]   w_op_b;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;

    rr_arbiter4 u_arb (
        .req        (req_valid),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .grant_id   (w_grant_id)
    );

    // The result register is free when empty, or when its content leaves this cycle.
    always_comb begin
        w_can_accept = 1'b0;
        if (rst) begin
            w_can_accept = 1'b0;
        end else if (r_state == EMPTY) begin
            w_can_accept = 1'b1;
        end else if (rsp_ready) begin
            w_can_accept = 1'b1;
        end else begin
            w_can_accept = 1'b0;
        end
    end

    assign req_ready  = w_can_accept ? w_grant : {NUM_REQ{1'b0}};
    assign w_transfer = |(req_valid & req_ready);

    // Steer the winner's operands onto the single shared adder.
    assign w_op_a = req_a[WIDTH*w_grant_id +: WIDTH];
    assign w_op_b = req_b[WIDTH*w_grant_id +: WIDTH];

    adder16 #(
        .WIDTH (WIDTH)
    ) u_add (
        .a    (w_op_a),
        .b    (w_op_b),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // EMPTY/FULL result-holding FSM with registered response, pointer and handshake counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= EMPTY;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= {ID_W{1'b0}};
            r_rsp_sum    <= {WIDTH{1'b0}};
            r_rsp_cout   <= 1'b0;
            r_op_count   <= 16'd0;
            r_last_grant <= 2'd3;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_transfer) begin
                        r_state     <= FULL;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_state     <= EMPTY;
                        r_rsp_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (rsp_ready && !w_transfer) begin
                        r_state     <= EMPTY;
                        r_rsp_valid <= 1'b0;
                    end else begin
                        r_state     <= FULL;
                        r_rsp_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_rsp_valid <= 1'b0;
                end
            endcase

            if (w_transfer) begin
                r_rsp_id     <= w_grant_id;
                r_rsp_sum    <= w_sum;
                r_rsp_cout   <= w_cout;
                r_last_grant <= w_grant_id;
            end else begin
                r_last_grant <= r_last_grant;
            end

            if (r_rsp_valid && rsp_ready) begin
                r_op_count <= r_op_count + 16'd1;
            end else begin
                r_op_count <= r_op_count;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_cout  = r_rsp_cout;
    assign op_count  = r_op_count;

endmodule : adder_arbiter

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed vector table plus
// hand-written multi-cycle sequences and a long wrap/scoreboard run.
module tb_adder_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_sum;
    logic        rsp_cout;
    logic [15:0] op_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    adder_arbiter #(
        .NUM_REQ (4),
        .WIDTH   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .op_count  (op_count)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  exp_ready;
        logic        exp_rv;
        logic [1:0]  exp_id;
        logic [15:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    vec_t tbl [8];
    int   corner [68];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lane k gets operand a = base_a + k so the operand mux is observable.
    task automatic set_lanes(input logic [15:0] base_a, input logic [15:0] b);
        for (int k = 0; k < 4; k++) begin
            req_a[16*k +: 16] = base_a + 16'(k);
            req_b[16*k +: 16] = b;
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [16:0] prev_exp;
        logic [16:0] cur_exp;
        logic [15:0] la;
        logic [15:0] lb;
        logic [3:0]  exp_rdy;

        rst       = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        req_a     = 64'd0;
        req_b     = 64'd0;

        for (int i = 0; i < 32; i++) corner[i] = i;
        for (int i = 0; i < 36; i++) corner[32 + i] = 65500 + i;

        tbl[0] = '{4'b0001, 16'h0001, 16'h0002, 4'b0001, 1'b1, 2'd0, 16'h0003, 1'b0};
        tbl[1] = '{4'b1111, 16'h1000, 16'h0001, 4'b0010, 1'b1, 2'd1, 16'h1002, 1'b0};
        tbl[2] = '{4'b0011, 16'h0010, 16'h0020, 4'b0001, 1'b1, 2'd0, 16'h0030, 1'b0};
        tbl[3] = '{4'b0100, 16'hFFFD, 16'h0001, 4'b0100, 1'b1, 2'd2, 16'h0000, 1'b1};
        tbl[4] = '{4'b1001, 16'hFFFC, 16'hFFFF, 4'b1000, 1'b1, 2'd3, 16'hFFFE, 1'b1};
        tbl[5] = '{4'b0000, 16'h1234, 16'h4321, 4'b0000, 1'b0, 2'd3, 16'hFFFE, 1'b1};
        tbl[6] = '{4'b1010, 16'h8000, 16'h8000, 4'b0010, 1'b1, 2'd1, 16'h0001, 1'b1};
        tbl[7] = '{4'b1010, 16'h8000, 16'h8000, 4'b1000, 1'b1, 2'd3, 16'h0003, 1'b1};

        // ---- reset state ----
        req_valid = 4'b1111;
        @(negedge clk);
        chk("ready_in_rst", 32'(req_ready), 32'h0);
        do_reset();
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_rsp_sum", 32'(rsp_sum), 32'h0);
        chk("rst_rsp_cout", 32'(rsp_cout), 32'h0);
        chk("rst_op_count", 32'(op_count), 32'h0);
        tick();

        // ---- directed vector table ----
        for (int r = 0; r < 8; r++) begin
            req_valid = tbl[r].valid;
            set_lanes(tbl[r].a, tbl[r].b);
            rsp_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", r), 32'(req_ready), 32'(tbl[r].exp_ready));
            tick();
            req_valid = 4'b0000;
            @(negedge clk);
            chk($sformatf("tbl%0d_rsp_valid", r), 32'(rsp_valid), 32'(tbl[r].exp_rv));
            chk($sformatf("tbl%0d_rsp_id", r), 32'(rsp_id), 32'(tbl[r].exp_id));
            chk($sformatf("tbl%0d_rsp_sum", r), 32'(rsp_sum), 32'(tbl[r].exp_sum));
            chk($sformatf("tbl%0d_rsp_cout", r), 32'(rsp_cout), 32'(tbl[r].exp_cout));
            tick();
        end
        @(negedge clk);
        chk("tbl_op_count", 32'(op_count), 32'd7);
        tick();

        // ---- all requesting, sink always ready: grants rotate 0,1,2,3,0 ----
        do_reset();
        set_lanes(16'h0000, 16'h0000);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            exp_rdy = 4'b0001 << (c % 4);
            @(negedge clk);
            chk($sformatf("rr_ready_c%0d", c), 32'(req_ready), 32'(exp_rdy));
            if (c > 0) begin
                chk($sformatf("rr_rsp_valid_c%0d", c), 32'(rsp_valid), 32'h1);
                chk($sformatf("rr_rsp_id_c%0d", c), 32'(rsp_id), 32'(c - 1));
            end
            tick();
        end

        // ---- backpressure: one transfer, then stall for 5 cycles ----
        do_reset();
        set_lanes(16'h0100, 16'h0005);
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_first_ready", 32'(req_ready), 32'h1);
        tick();
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp_ready_c%0d", c), 32'(req_ready), 32'h0);
            chk($sformatf("bp_rsp_valid_c%0d", c), 32'(rsp_valid), 32'h1);
            chk($sformatf("bp_rsp_id_c%0d", c), 32'(rsp_id), 32'h0);
            chk($sformatf("bp_rsp_sum_c%0d", c), 32'(rsp_sum), 32'h0105);
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_drain_ready", 32'(req_ready), 32'h2);
        chk("bp_drain_id", 32'(rsp_id), 32'h0);
        tick();
        @(negedge clk);
        chk("bp_next_id", 32'(rsp_id), 32'h1);
        chk("bp_next_sum", 32'(rsp_sum), 32'h0106);
        chk("bp_op_count", 32'(op_count), 32'h1);
        tick();

        // ---- reset while FULL ----
        rsp_ready = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 32'(req_ready), 32'h0);
        chk("midrst_full", 32'(rsp_valid), 32'h1);
        chk("midrst_pre_id", 32'(rsp_id), 32'h2);
        chk("midrst_pre_count", 32'(op_count), 32'h2);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("midrst_op_count", 32'(op_count), 32'h0);
        chk("midrst_first_grant", 32'(req_ready), 32'h1);
        tick();

        // ---- 65536 back-to-back handshakes with corner operands ----
        do_reset();
        rsp_ready = 1'b1;
        prev_exp  = 17'd0;
        for (int n = 0; n <= 65536; n++) begin
            cur_exp = 17'd0;
            if (n < 65536) begin
                req_valid = 4'b1111;
                for (int k = 0; k < 4; k++) begin
                    la = 16'(corner[(n + k) % 68]);
                    lb = 16'(corner[(3 * n + k + 5) % 68]);
                    req_a[16*k +: 16] = la;
                    req_b[16*k +: 16] = lb;
                    if (k == n % 4) cur_exp = {1'b0, la} + {1'b0, lb};
                end
            end else begin
                req_valid = 4'b0000;
            end
            @(negedge clk);
            if (n < 65536) begin
                exp_rdy = 4'b0001 << (n % 4);
                chk("sb_ready", 32'(req_ready), 32'(exp_rdy));
            end
            if (n > 0) begin
                chk("sb_rsp_valid", 32'(rsp_valid), 32'h1);
                chk("sb_rsp_id", 32'(rsp_id), 32'((n - 1) % 4));
                chk("sb_result", 32'({rsp_cout, rsp_sum}), 32'(prev_exp));
            end
            if (n == 65535) begin
                chk("sb_op_count_pre_wrap", 32'(op_count), 32'd65534);
            end
            prev_exp = cur_exp;
            tick();
        end
        @(negedge clk);
        chk("sb_op_count_wrap", 32'(op_count), 32'h0);
        chk("sb_final_rsp_valid", 32'(rsp_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_adder_arbiter

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the adder (fixed 4 for this release).
REQ-002 SHALL have parameter WIDTH, default 16, operand width matching the existing 16-bit adder.
REQ-003 SHALL have one clock and a synchronous active-high reset; no other clock or reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req_valid  input  4  per-requester request valid.
REQ-007 req_a  input  64  packed operand A; requester k at bits [16k+15:16k].
REQ-008 req_b  input  64  packed operand B; same packing as req_a.
REQ-009 req_ready  output  4  one-hot accept; a request transfers when req_valid[k] and req_ready[k] are both high.
REQ-010 rsp_valid  output  1  result register holds a valid result.
REQ-011 rsp_ready  input  1  downstream accepts the result this cycle.
REQ-012 rsp_id  output  2  index of the requester that owns the result.
REQ-013 rsp_sum  output  16  registered sum, a+b mod 2^16.
REQ-014 rsp_cout  output  1  registered carry-out; {rsp_cout,rsp_sum} == a+b as 17 bits.
REQ-015 op_count  output  16  number of completed response handshakes, wrapping modulo 2^16.

Function
REQ-016 SHALL use exactly one instance of the 16-bit adder; the arbiter multiplexes the granted operands onto it.
REQ-017 FSM states: EMPTY (result register free), FULL (result held); reset enters EMPTY.
REQ-018 can_accept = (state==EMPTY) or (state==FULL and rsp_ready).
REQ-019 When can_accept and any req_valid is high, req_ready SHALL be one-hot on the round-robin winner; otherwise req_ready SHALL be 4'b0000.
REQ-020 req_ready SHALL depend combinationally on req_valid, state, rsp_ready and pointer only; req_ready[k] never asserts without req_valid[k].
REQ-021 Round-robin: search starts at index (last_grant+1) mod 4, ascending with wrap; last_grant updates only on a transfer.
REQ-022 Latency: a request transferred in cycle N SHALL present rsp_valid, rsp_id, rsp_sum, rsp_cout in cycle N+1.
REQ-023 EMPTY->FULL on transfer; FULL->EMPTY on rsp_ready with no new transfer; FULL->FULL on rsp_ready with transfer (back-to-back, one result per cycle); FULL holds outputs stable while rsp_ready low.
REQ-024 rsp_sum/rsp_cout/rsp_id SHALL change only on a transfer.
REQ-025 op_count SHALL increment by 1 on each rsp_valid&&rsp_ready cycle; 16'hFFFF wraps to 16'h0000.
REQ-026 Operand boundaries: 16'hFFFF+16'h0001 SHALL give rsp_sum=16'h0000, rsp_cout=1; 16'hFFFF+16'hFFFF gives 16'hFFFE, cout=1.
REQ-027 A requester dropping req_valid before being granted SHALL lose its request with no side effects.

Reset
REQ-028 While rst is high at a clock edge: state=EMPTY, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, op_count=0, last_grant=3 (so first search starts at 0).
REQ-029 req_ready SHALL be 4'b0000 in any cycle where rst is high.
REQ-030 Reset mid-operation SHALL discard a held result without completing its handshake and without incrementing op_count.

Structure
REQ-031 Shared package adder_arb_pkg SHALL hold NUM_REQ, WIDTH, ID_W (2) and the state encoding EMPTY/FULL.
REQ-032 Round-robin winner selection SHALL be a sub-module rr_arbiter4 (inputs req[3:0], last_grant[1:0]; outputs one-hot grant, grant_id).
REQ-033 The existing adder module SHALL be instantiated unmodified as the datapath.

Verification
REQ-034 Reset then req_valid=4'b1111, rsp_ready=1 held -> grants 0,1,2,3,0 on consecutive cycles; rsp_id sequence 0,1,2,3 one cycle later.
REQ-035 Requester 2 alone, a=16'hFFFF, b=16'h0001, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=2, rsp_sum=16'h0000, rsp_cout=1.
REQ-036 rsp_ready=0 for 5 cycles while all request -> exactly one transfer, then req_ready=0 and outputs stable; rsp_ready=1 -> result drained and next grant same cycle.
REQ-037 Assert rst while FULL -> next cycle rsp_valid=0, op_count=0, first grant after release goes to requester 0.
REQ-038 65 536 completed handshakes -> op_count returns to 16'h0000; scoreboard checks every {rsp_cout,rsp_sum} equals 17-bit a+b for corner operands 0..31 and 65500..65535.
